// File: rtl/shared_mem_arbiter.sv
// Arbitrates one synchronous single-port RAM between instruction fetch and data access.
// Data side has priority; a saturating starvation counter bounds the fetch stall.
module shared_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  logic [CNT_W-1:0]             starve_q, starve_d;
  tag_t [MEM_LATENCY-1:0]       tag_q, tag_d;
  tag_t                         tag_in;
  tag_t                         resp;
  logic                         fetch_wins;

  // Fetch only overrides data once it has been denied STARVE_LIMIT cycles in a row.
  assign fetch_wins = i_req && (starve_q == CNT_MAX);

  assign d_gnt = !reset && d_req && !fetch_wins;
  assign i_gnt = !reset && i_req && (fetch_wins || !d_req);

  assign mem_en    = i_gnt || d_gnt;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign mem_wdata = d_gnt ? d_wdata : '0;

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_comb begin
    tag_in.valid = i_gnt || (d_gnt && !d_we);
    tag_in.owner = d_gnt ? OWNER_D : OWNER_I;
    tag_d[0]     = tag_in;
    for (int k = 1; k < MEM_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // NOTE: only the control state (counter and tag valids) needs reset; the RAM contents and
  // data paths are qualified by those valids, so they are left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      tag_q    <= '0;
    end else begin
      starve_q <= starve_d;
      tag_q    <= tag_d;
    end
  end

  // A response whose tag is already in the last stage when reset rises is dropped too.
  assign resp     = tag_q[MEM_LATENCY-1];
  assign i_rvalid = !reset && resp.valid && (resp.owner == OWNER_I);
  assign d_rvalid = !reset && resp.valid && (resp.owner == OWNER_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: a MEM_LATENCY=1 and a MEM_LATENCY=3 instance share
// stimulus, each backed by a small RAM model whose unwritten words read back as their address.
module tb_shared_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, mem_en1, mem_we1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  // RAM models: 1024 words indexed by addr[11:2]; a word never written reads as its address.
  logic [31:0] mem1 [1024];
  logic        wr1  [1024] = '{default: 1'b0};
  logic [31:0] rp1;
  logic [31:0] mem3 [1024];
  logic        wr3  [1024] = '{default: 1'b0};
  logic [31:0] rp3 [3];

  always @(posedge clk) begin
    if (mem_en1 && mem_we1) begin
      mem1[mem_addr1[11:2]] <= mem_wdata1;
      wr1[mem_addr1[11:2]]  <= 1'b1;
    end
    rp1 <= (mem_en1 && !mem_we1) ?
           (wr1[mem_addr1[11:2]] ? mem1[mem_addr1[11:2]] : {mem_addr1[31:2], 2'b00}) : 32'h0;
  end
  assign mem_rdata1 = rp1;

  always @(posedge clk) begin
    if (mem_en3 && mem_we3) begin
      mem3[mem_addr3[11:2]] <= mem_wdata3;
      wr3[mem_addr3[11:2]]  <= 1'b1;
    end
    rp3[0] <= (mem_en3 && !mem_we3) ?
              (wr3[mem_addr3[11:2]] ? mem3[mem_addr3[11:2]] : {mem_addr3[31:2], 2'b00}) : 32'h0;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign mem_rdata3 = rp3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before checks.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] dwd);
    @(negedge clk);
    reset   = rst;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    #1;
  endtask

  // Alternating I/D read table for the latency-3 instance.
  logic        alt_ir [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] alt_ia [7] = '{32'h10, 32'h0, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        alt_dr [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] alt_da [7] = '{32'h0, 32'h600, 32'h0, 32'h604, 32'h0, 32'h0, 32'h0};
  logic        alt_iv [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        alt_dv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] alt_id [7] = '{32'h0, 32'h0, 32'h0, 32'h10, 32'h0, 32'h14, 32'h0};
  logic [31:0] alt_dd [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h600, 32'h0, 32'h604};

  initial begin
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset: requests present but nothing may be granted.
    step(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h100, 32'h55);
    check("rst_i_gnt",  32'(i_gnt1),  32'h0);
    check("rst_d_gnt",  32'(d_gnt1),  32'h0);
    check("rst_mem_en", 32'(mem_en1), 32'h0);
    check("rst_mem_we", 32'(mem_we1), 32'h0);
    check("rst_d_gnt3", 32'(d_gnt3),  32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Fetch-only stream 0x0, 0x4, 0x8.
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("f0_i_gnt",    32'(i_gnt1),    32'h1);
    check("f0_mem_en",   32'(mem_en1),   32'h1);
    check("f0_mem_addr", mem_addr1,      32'h0);
    check("f0_i_rvalid", 32'(i_rvalid1), 32'h0);
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    check("f1_i_gnt",    32'(i_gnt1),    32'h1);
    check("f1_mem_addr", mem_addr1,      32'h4);
    check("f1_i_rvalid", 32'(i_rvalid1), 32'h1);
    check("f1_i_rdata",  i_rdata1,       32'h0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    check("f2_i_rvalid", 32'(i_rvalid1), 32'h1);
    check("f2_i_rdata",  i_rdata1,       32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("f3_i_rdata",  i_rdata1,       32'h8);
    check("f3_i_gnt",    32'(i_gnt1),    32'h0);
    check("f3_mem_en",   32'(mem_en1),   32'h0);
    check("f3_mem_addr", mem_addr1,      32'h0);

    // Data read and fetch in the same cycle: data wins, fetch follows.
    step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    check("dr_d_gnt",    32'(d_gnt1),    32'h1);
    check("dr_i_gnt",    32'(i_gnt1),    32'h0);
    check("dr_mem_addr", mem_addr1,      32'h100);
    step(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("dr_d_rvalid", 32'(d_rvalid1), 32'h1);
    check("dr_d_rdata",  d_rdata1,       32'h100);
    check("dr_i_rvalid", 32'(i_rvalid1), 32'h0);
    check("dr_i_gnt2",   32'(i_gnt1),    32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("dr_i_rvalid2", 32'(i_rvalid1), 32'h1);
    check("dr_d_rvalid2", 32'(d_rvalid1), 32'h0);

    // Data write, read back, then a write granted alongside the read response.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
    check("wr_d_gnt",     32'(d_gnt1),  32'h1);
    check("wr_mem_we",    32'(mem_we1), 32'h1);
    check("wr_mem_addr",  mem_addr1,    32'h200);
    check("wr_mem_wdata", mem_wdata1,   32'hDEADBEEF);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    check("wr_no_rvalid", 32'(d_rvalid1), 32'h0);
    check("rb_mem_we",    32'(mem_we1),   32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h304, 32'h12345678);
    check("rb_d_rvalid",  32'(d_rvalid1), 32'h1);
    check("rb_d_rdata",   d_rdata1,       32'hDEADBEEF);
    check("ww_mem_we",    32'(mem_we1),   32'h1);
    check("ww_mem_wdata", mem_wdata1,     32'h12345678);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("ww_no_rvalid", 32'(d_rvalid1), 32'h0);
    check("ww_d_rdata",   d_rdata1,       32'h0);

    // Starvation: both requesting for 10 cycles, fetch wins cycles 5 and 10.
    for (int c = 1; c <= 10; c++) begin
      logic exp_i;
      exp_i = (c == 5) || (c == 10);
      step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h400, 32'h0);
      check($sformatf("st%0d_i_gnt", c), 32'(i_gnt1), 32'(exp_i));
      check($sformatf("st%0d_d_gnt", c), 32'(d_gnt1), 32'(!exp_i));
      if (c == 6 || c == 1) begin
        check($sformatf("st%0d_i_rvalid", c), 32'(i_rvalid1), 32'(c == 6));
      end
      if (c == 6) check("st6_i_rdata", i_rdata1, 32'h40);
      if (c >= 2) check($sformatf("st%0d_d_rvalid", c), 32'(d_rvalid1), 32'(c != 6));
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("st_end_i_rdata", i_rdata1, 32'h40);

    // Reset while a read is in flight: it must never respond.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0);
    check("mf_d_gnt",  32'(d_gnt1), 32'h1);
    check("mf_d_gnt3", 32'(d_gnt3), 32'h1);
    step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h504, 32'h0);
    check("mf_rst_i_gnt",    32'(i_gnt1),    32'h0);
    check("mf_rst_d_gnt",    32'(d_gnt1),    32'h0);
    check("mf_rst_mem_en3",  32'(mem_en3),   32'h0);
    check("mf_rst_d_rvalid", 32'(d_rvalid1), 32'h0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      check($sformatf("mf%0d_d_rvalid", c),  32'(d_rvalid1), 32'h0);
      check($sformatf("mf%0d_d_rvalid3", c), 32'(d_rvalid3), 32'h0);
      check($sformatf("mf%0d_i_rvalid3", c), 32'(i_rvalid3), 32'h0);
    end

    // Latency-3 instance: alternating fetch/data reads return in order three cycles later.
    for (int c = 0; c < 7; c++) begin
      step(1'b0, alt_ir[c], alt_ia[c], alt_dr[c], 1'b0, alt_da[c], 32'h0);
      check($sformatf("l3c%0d_i_gnt", c),    32'(i_gnt3),    32'(alt_ir[c]));
      check($sformatf("l3c%0d_d_gnt", c),    32'(d_gnt3),    32'(alt_dr[c]));
      check($sformatf("l3c%0d_i_rvalid", c), 32'(i_rvalid3), 32'(alt_iv[c]));
      check($sformatf("l3c%0d_d_rvalid", c), 32'(d_rvalid3), 32'(alt_dv[c]));
      check($sformatf("l3c%0d_i_rdata", c),  i_rdata3,       alt_id[c]);
      check($sformatf("l3c%0d_d_rdata", c),  d_rdata3,       alt_dd[c]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
